// File: rtl/iot_mon_pkg.sv
// iot_mon_pkg: shared constants, count type and clog2 helper for the active-device monitor
package iot_mon_pkg;

    localparam int DEF_N_DEV    = 16;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_DEDUP    = 1;
    localparam int DEF_ALARM_HI = 12;
    localparam int DEF_ALARM_LO = 8;

    // Wide enough for any legal counter width; narrower counts are zero-extended.
    localparam int OCC_W = 16;

    typedef logic [OCC_W-1:0] occupancy_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/iot_alarm_hyst.sv
// iot_alarm_hyst: registered hysteretic threshold flag on the post-update occupancy
module iot_alarm_hyst
    import iot_mon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  occupancy_t count,
    input  occupancy_t alarm_hi,
    input  occupancy_t alarm_lo,
    output logic       alarm
);

    logic r_alarm;

    // Set at or above the high mark, clear at or below the low mark, hold in between.
    always_ff @(posedge clk) begin
        if (rst)                    r_alarm <= 1'b0;
        else if (count >= alarm_hi) r_alarm <= 1'b1;
        else if (count <= alarm_lo) r_alarm <= 1'b0;
    end

    assign alarm = r_alarm;

endmodule

// File: rtl/iot_active_monitor.sv
// iot_active_monitor: tracks on/off device events into an active map, occupancy count, peak and alarm
module iot_active_monitor
    import iot_mon_pkg::*;
#(
    parameter  int N_DEV    = DEF_N_DEV,
    parameter  int CNT_W    = DEF_CNT_W,
    parameter  int DEDUP    = DEF_DEDUP,
    parameter  int ALARM_HI = DEF_ALARM_HI,
    parameter  int ALARM_LO = DEF_ALARM_LO,
    localparam int ID_W     = (clog2(N_DEV) < 1) ? 1 : clog2(N_DEV)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic             on_off,
    input  logic [ID_W-1:0]  dev_id,
    input  logic             clr_peak,
    output logic [CNT_W-1:0] counter_out,
    output logic [N_DEV-1:0] active_map,
    output logic [CNT_W-1:0] peak_out,
    output logic             alarm,
    output logic             dup_evt,
    output logic             bad_id
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (N_DEV < 2 || N_DEV > 256) begin : g_bad_ndev
        $error("N_DEV must be in 2..256");
    end
    if ((2 ** CNT_W) - 1 < N_DEV) begin : g_bad_cntw
        $error("CNT_W too narrow to count N_DEV devices");
    end
    if (CNT_W > OCC_W) begin : g_bad_occ
        $error("CNT_W exceeds occupancy_t width");
    end
    if (ALARM_LO >= ALARM_HI) begin : g_bad_thr
        $error("ALARM_LO must be below ALARM_HI");
    end

    logic [N_DEV-1:0] r_map;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_peak;
    logic             r_dup;
    logic             r_bad;

    logic [N_DEV-1:0] w_onehot;
    logic [N_DEV-1:0] w_map_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_id_ok;
    logic             w_cur;
    logic             w_inc;
    logic             w_dec;
    logic             w_dup;
    logic             w_bad;

    // Classify the event: real transition, redundant/saturated, or out-of-range id.
    always_comb begin
        w_onehot  = N_DEV'(1) << dev_id;
        w_id_ok   = (DEDUP == 0) || (int'(dev_id) < N_DEV);
        w_cur     = |(r_map & w_onehot);
        w_inc     = change & w_id_ok & on_off & ((DEDUP != 0) ? ~w_cur : (r_cnt != CNT_MAX));
        w_dec     = change & w_id_ok & ~on_off & ((DEDUP != 0) ? w_cur : (r_cnt != '0));
        w_bad     = change & ~w_id_ok;
        w_dup     = change & w_id_ok & ~w_inc & ~w_dec;
        w_cnt_nxt = r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
        w_map_nxt = (DEDUP == 0) ? '0 :
                    w_inc        ? (r_map | w_onehot) :
                    w_dec        ? (r_map & ~w_onehot) : r_map;
    end

    // Commit map, count, pulses and peak; clr_peak reloads with this cycle's count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_map  <= '0;
            r_cnt  <= '0;
            r_peak <= '0;
            r_dup  <= 1'b0;
            r_bad  <= 1'b0;
        end else begin
            r_map <= w_map_nxt;
            r_cnt <= w_cnt_nxt;
            r_dup <= w_dup;
            r_bad <= w_bad;
            if (clr_peak || (w_cnt_nxt > r_peak)) r_peak <= w_cnt_nxt;
        end
    end

    iot_alarm_hyst u_alarm (
        .clk      (clk),
        .rst      (rst),
        .count    (occupancy_t'(w_cnt_nxt)),
        .alarm_hi (occupancy_t'(ALARM_HI)),
        .alarm_lo (occupancy_t'(ALARM_LO)),
        .alarm    (alarm)
    );

    assign counter_out = r_cnt;
    assign active_map  = r_map;
    assign peak_out    = r_peak;
    assign dup_evt     = r_dup;
    assign bad_id      = r_bad;

endmodule

// File: tb/tb_iot_active_monitor.sv
// tb_iot_active_monitor: directed vectors with a queued scoreboard across three monitor configurations
module tb_iot_active_monitor;

    logic       clk;
    logic       rst;
    logic       change;
    logic       on_off;
    logic [3:0] dev_id;
    logic       clr_peak;

    logic [7:0]  a_cnt, a_peak, c_cnt, c_peak;
    logic [15:0] a_map;
    logic [3:0]  b_cnt, b_peak;
    logic [11:0] b_map, c_map;
    logic        a_al, a_dup, a_bad;
    logic        b_al, b_dup, b_bad;
    logic        c_al, c_dup, c_bad;

    typedef struct {
        int w;
        int cnt;
        int map;
        int peak;
        int al;
        int dup;
        int bad;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   ac, am, ap, aa, ad, ab;
    int   n_vec = 0;
    int   n_err = 0;

    // Tracked config: 16 devices, 8-bit count.
    iot_active_monitor #(.N_DEV(16), .CNT_W(8), .DEDUP(1), .ALARM_HI(4), .ALARM_LO(2)) u_a (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off), .dev_id(dev_id), .clr_peak(clr_peak),
        .counter_out(a_cnt), .active_map(a_map), .peak_out(a_peak), .alarm(a_al),
        .dup_evt(a_dup), .bad_id(a_bad));

    // Legacy up/down counter, 4-bit so saturation is reachable.
    iot_active_monitor #(.N_DEV(12), .CNT_W(4), .DEDUP(0), .ALARM_HI(4), .ALARM_LO(2)) u_b (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off), .dev_id(dev_id), .clr_peak(clr_peak),
        .counter_out(b_cnt), .active_map(b_map), .peak_out(b_peak), .alarm(b_al),
        .dup_evt(b_dup), .bad_id(b_bad));

    // Tracked config with unused id space (12..15 are bad ids).
    iot_active_monitor #(.N_DEV(12), .CNT_W(8), .DEDUP(1), .ALARM_HI(4), .ALARM_LO(2)) u_c (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off), .dev_id(dev_id), .clr_peak(clr_peak),
        .counter_out(c_cnt), .active_map(c_map), .peak_out(c_peak), .alarm(c_al),
        .dup_evt(c_dup), .bad_id(c_bad));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int w, input int a, input int x);
        n_vec++;
        if (a != x) begin
            n_err++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", w, nm, a, x, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue its expected post-edge outputs.
    task automatic step(input int w, input bit r, input bit c, input bit o, input int id, input bit cp,
                        input int ec, input int em, input int ep, input int ea, input int ed, input int eb);
        exp_t x;
        rst      = r;
        change   = c;
        on_off   = o;
        dev_id   = 4'(id);
        clr_peak = cp;
        @(posedge clk);
        x.w = w; x.cnt = ec; x.map = em; x.peak = ep; x.al = ea; x.dup = ed; x.bad = eb;
        q.push_back(x);
        #1;
    endtask

    // Monitor: every output cycle pops one expectation and compares the selected DUT.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.w == 0) begin
                ac = int'(a_cnt); am = int'(a_map); ap = int'(a_peak);
                aa = int'(a_al);  ad = int'(a_dup); ab = int'(a_bad);
            end else if (e.w == 1) begin
                ac = int'(b_cnt); am = int'(b_map); ap = int'(b_peak);
                aa = int'(b_al);  ad = int'(b_dup); ab = int'(b_bad);
            end else begin
                ac = int'(c_cnt); am = int'(c_map); ap = int'(c_peak);
                aa = int'(c_al);  ad = int'(c_dup); ab = int'(c_bad);
            end
            chk("counter_out", e.w, ac, e.cnt);
            chk("active_map",  e.w, am, e.map);
            chk("peak_out",    e.w, ap, e.peak);
            chk("alarm",       e.w, aa, e.al);
            chk("dup_evt",     e.w, ad, e.dup);
            chk("bad_id",      e.w, ab, e.bad);
            if (e.w != 1) chk("popcount", e.w, $countones(am), ac);
        end
    end

    initial begin
        int cv;
        rst = 1'b1; change = 1'b0; on_off = 1'b0; dev_id = '0; clr_peak = 1'b0;

        // Reset held with an active event stream, then first event accepted.
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 3, 0, 1, 'h8, 1, 0, 0, 0);
        // Deduplication.
        step(0, 0, 1, 1, 3, 0, 1, 'h8, 1, 0, 1, 0);
        step(0, 0, 0, 1, 3, 0, 1, 'h8, 1, 0, 0, 0);
        step(0, 0, 1, 0, 5, 0, 1, 'h8, 1, 0, 1, 0);
        // Reset wins over change and clr_peak.
        step(0, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        // Hysteresis.
        step(0, 0, 1, 1, 0, 0, 1, 'h01, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 2, 'h03, 2, 0, 0, 0);
        step(0, 0, 1, 1, 2, 0, 3, 'h07, 3, 0, 0, 0);
        step(0, 0, 1, 1, 3, 0, 4, 'h0F, 4, 1, 0, 0);
        step(0, 0, 1, 1, 4, 0, 5, 'h1F, 5, 1, 0, 0);
        step(0, 0, 1, 0, 4, 0, 4, 'h0F, 5, 1, 0, 0);
        step(0, 0, 1, 0, 3, 0, 3, 'h07, 5, 1, 0, 0);
        step(0, 0, 1, 0, 2, 0, 2, 'h03, 5, 0, 0, 0);
        // Peak hold and clear with a simultaneous event.
        step(0, 0, 1, 0, 1, 0, 1, 'h01, 5, 0, 0, 0);
        step(0, 0, 1, 1, 7, 1, 2, 'h81, 2, 0, 0, 0);
        step(0, 0, 0, 1, 7, 0, 2, 'h81, 2, 0, 0, 0);
        // Back-to-back opposite events net to zero.
        step(0, 0, 1, 1, 9, 0, 3, 'h281, 3, 0, 0, 0);
        step(0, 0, 1, 0, 9, 0, 2, 'h81, 3, 0, 0, 0);
        step(0, 0, 0, 0, 9, 1, 2, 'h81, 2, 0, 0, 0);

        // Legacy saturation, 4-bit counter; dev_id is ignored.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cv = (i > 15) ? 15 : i;
            step(1, 0, 1, 1, 13, 0, cv, 0, cv, int'(cv >= 4), int'(i > 15), 0);
        end
        for (int i = 1; i <= 20; i++) begin
            cv = (i >= 15) ? 0 : 15 - i;
            step(1, 0, 1, 0, 13, 0, cv, 0, 15, int'(cv > 2), int'(i > 15), 0);
        end

        // Bad ids and mid-burst reset on a 12-device map.
        step(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 1, 1, 1, 0, 1, 'h2, 1, 0, 0, 0);
        step(2, 0, 1, 1, 13, 0, 1, 'h2, 1, 0, 0, 1);
        step(2, 0, 1, 0, 15, 0, 1, 'h2, 1, 0, 0, 1);
        step(2, 0, 0, 0, 15, 0, 1, 'h2, 1, 0, 0, 0);
        step(2, 0, 1, 1, 2, 0, 2, 'h6, 2, 0, 0, 0);
        step(2, 0, 1, 1, 3, 0, 3, 'hE, 3, 0, 0, 0);
        step(2, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 1, 1, 5, 0, 1, 'h20, 1, 0, 0, 0);
        step(2, 0, 1, 0, 5, 0, 0, 0, 1, 0, 0, 0);
        step(2, 0, 1, 1, 11, 0, 1, 'h800, 1, 0, 0, 0);
        step(2, 0, 1, 0, 12, 0, 1, 'h800, 1, 0, 0, 1);
        step(2, 0, 0, 0, 0, 0, 1, 'h800, 1, 0, 0, 0);

        change = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
